// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation codes, aluOp encodings and FSM states shared by the multi-cycle ALU
package alu_pkg;
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;
   // M codes live in their own space, selected by the decoded m flag; low 3 bits equal funct3
   localparam logic [3:0] ALU_MUL    = 4'd0;
   localparam logic [3:0] ALU_MULH   = 4'd1;
   localparam logic [3:0] ALU_MULHSU = 4'd2;
   localparam logic [3:0] ALU_MULHU  = 4'd3;
   localparam logic [3:0] ALU_DIV    = 4'd4;
   localparam logic [3:0] ALU_DIVU   = 4'd5;
   localparam logic [3:0] ALU_REM    = 4'd6;
   localparam logic [3:0] ALU_REMU   = 4'd7;
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_ADD2  = 2'b11;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} state_t;
   typedef struct packed {
      logic       m;
      logic [3:0] code;
   } dec_t;
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative shift-add multiplier / restoring divider with sign fix-up and fast paths
module muldiv_iter import alu_pkg::*; #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load_i,
   input  logic            step_i,
   input  logic [2:0]      fn_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            fast_o,
   output logic [XLEN-1:0] fast_res_o,
   output logic            last_o,
   output logic [XLEN-1:0] res_o
);
   localparam int CW = $clog2(XLEN);
   logic            sa, sb, div_zero, div_ovf, ge;
   logic [XLEN-1:0] ma, mb, hi_d, lo_d;
   logic [XLEN-1:0] hi_q, lo_q, mc_q;
   logic [XLEN:0]   sum, rs;
   logic [2*XLEN-1:0] prod;
   logic [2:0]      fn_q;
   logic            neg_q, negr_q;
   logic [CW-1:0]   cnt_q;
   // operand signedness, magnitudes and divide special cases, evaluated on the incoming request
   always_comb begin
      sa = a_i[XLEN-1] && (fn_i == ALU_MULH[2:0] || fn_i == ALU_MULHSU[2:0] || (fn_i[2] && !fn_i[0]));
      sb = b_i[XLEN-1] && (fn_i == ALU_MULH[2:0] || (fn_i[2] && !fn_i[0]));
      ma = sa ? -a_i : a_i;
      mb = sb ? -b_i : b_i;
      div_zero = fn_i[2] && b_i == '0;
      div_ovf = fn_i[2] && !fn_i[0] && a_i == {1'b1, {(XLEN-1){1'b0}}} && (&b_i);
      fast_o = div_zero || div_ovf;
      fast_res_o = fn_i[1] ? (div_ovf ? '0 : a_i) : (div_ovf ? a_i : '1);
   end
   // one iteration step plus the signed result of the state after that step
   always_comb begin
      sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : '0);
      rs = {hi_q, lo_q[XLEN-1]};
      ge = rs >= {1'b0, mc_q};
      hi_d = fn_q[2] ? (ge ? XLEN'(rs - {1'b0, mc_q}) : rs[XLEN-1:0]) : sum[XLEN:1];
      lo_d = fn_q[2] ? {lo_q[XLEN-2:0], ge} : {sum[0], lo_q[XLEN-1:1]};
      prod = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
      res_o = fn_q[2] ? (fn_q[1] ? (negr_q ? -hi_d : hi_d) : (neg_q ? -lo_d : lo_d))
                      : (fn_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
      last_o = cnt_q == CW'(XLEN-1);
   end
   // latch magnitudes and signs on load, then advance one bit per step
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q <= '0;
         lo_q <= '0;
         mc_q <= '0;
         fn_q <= '0;
         neg_q <= 1'b0;
         negr_q <= 1'b0;
         cnt_q <= '0;
      end else if (load_i) begin
         hi_q <= '0;
         lo_q <= ma;
         mc_q <= mb;
         fn_q <= fn_i;
         neg_q <= sa ^ sb;
         negr_q <= sa;
         cnt_q <= '0;
      end else if (step_i) begin
         hi_q <= hi_d;
         lo_q <= lo_d;
         cnt_q <= cnt_q + 1'b1;
      end
   end
endmodule

// File: rtl/alu_exec_multiciclo.sv
// alu_exec_multiciclo: decoded RV32I/M ALU with single-cycle base ops and iterative mul/div
module alu_exec_multiciclo import alu_pkg::*; #(
   parameter int XLEN     = 32,
   parameter bit ENABLE_M = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            op,
   input  logic            f7,
   input  logic            f7_0,
   input  logic [2:0]      f3,
   input  logic [1:0]      aluOp,
   input  logic [XLEN-1:0] srcA,
   input  logic [XLEN-1:0] srcB,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            zero
);
   localparam int SW = $clog2(XLEN);
   dec_t            dec;
   logic [SW-1:0]   shamt;
   logic [XLEN-1:0] base_res, fast_res, md_res, new_res;
   logic            fast, last, accept, ld;
   state_t          state_q;
   logic            busy_q, done_q, zero_q;
   logic [XLEN-1:0] result_q;
   // decode control fields into an operation code
   always_comb begin
      dec.m = aluOp == ALUOP_FUNCT && op && f7_0 && ENABLE_M;
      dec.code = ALU_ADD;
      if (dec.m) dec.code = {1'b0, f3};
      else if (aluOp == ALUOP_SUB) dec.code = ALU_SUB;
      else if (aluOp == ALUOP_FUNCT)
         case (f3)
            3'b000: dec.code = (op && f7) ? ALU_SUB : ALU_ADD;
            3'b001: dec.code = ALU_SLL;
            3'b010: dec.code = ALU_SLT;
            3'b011: dec.code = ALU_SLTU;
            3'b100: dec.code = ALU_XOR;
            3'b101: dec.code = f7 ? ALU_SRA : ALU_SRL;
            3'b110: dec.code = ALU_OR;
            default: dec.code = ALU_AND;
         endcase
   end
   // single-cycle base ALU on the incoming operands
   always_comb begin
      shamt = srcB[SW-1:0];
      case (dec.code)
         ALU_SUB:  base_res = srcA - srcB;
         ALU_SLL:  base_res = srcA << shamt;
         ALU_SLT:  base_res = XLEN'($signed(srcA) < $signed(srcB));
         ALU_SLTU: base_res = XLEN'(srcA < srcB);
         ALU_XOR:  base_res = srcA ^ srcB;
         ALU_SRL:  base_res = srcA >> shamt;
         ALU_SRA:  base_res = $signed(srcA) >>> shamt;
         ALU_OR:   base_res = srcA | srcB;
         ALU_AND:  base_res = srcA & srcB;
         default:  base_res = srcA + srcB;
      endcase
      accept = start && (state_q == S_IDLE || state_q == S_DONE);
      ld = accept && dec.m && !fast;
      new_res = dec.m ? fast_res : base_res;
   end
   muldiv_iter #(.XLEN(XLEN)) u_md (
      .clk        (clk),
      .reset      (reset),
      .load_i     (ld),
      .step_i     (state_q == S_EXEC),
      .fn_i       (dec.code[2:0]),
      .a_i        (srcA),
      .b_i        (srcB),
      .fast_o     (fast),
      .fast_res_o (fast_res),
      .last_o     (last),
      .res_o      (md_res)
   );
   // control FSM: accept requests, iterate M ops, publish result with a one-cycle done
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         result_q <= '0;
         zero_q <= 1'b1;
      end else if (accept) begin
         state_q <= ld ? S_EXEC : S_DONE;
         busy_q <= 1'b1;
         done_q <= !ld;
         if (!ld) begin
            result_q <= new_res;
            zero_q <= new_res == '0;
         end
      end else if (state_q == S_EXEC) begin
         if (last) begin
            state_q <= S_DONE;
            done_q <= 1'b1;
            result_q <= md_res;
            zero_q <= md_res == '0;
         end
      end else begin
         state_q <= S_IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end
   end
   assign busy = busy_q;
   assign done = done_q;
   assign result = result_q;
   assign zero = zero_q;
endmodule

// File: tb/tb_alu_exec_multiciclo.sv
// tb_alu_exec_multiciclo: directed and random checks of the multi-cycle ALU against an arithmetic model
module tb_alu_exec_multiciclo;
   logic clk = 1'b0;
   logic reset, start, op, f7, f7_0;
   logic [2:0] f3;
   logic [1:0] aluOp;
   logic [31:0] srcA, srcB;
   logic busy, done, zero, busy2, done2, zero2;
   logic [31:0] result, result2;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   alu_exec_multiciclo #(.XLEN(32), .ENABLE_M(1'b1)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .f7(f7), .f7_0(f7_0), .f3(f3),
      .aluOp(aluOp), .srcA(srcA), .srcB(srcB), .busy(busy), .done(done), .result(result), .zero(zero)
   );
   alu_exec_multiciclo #(.XLEN(32), .ENABLE_M(1'b0)) dut_nom (
      .clk(clk), .reset(reset), .start(start), .op(op), .f7(f7), .f7_0(f7_0), .f3(f3),
      .aluOp(aluOp), .srcA(srcA), .srcB(srcB), .busy(busy2), .done(done2), .result(result2), .zero(zero2)
   );

   function automatic logic [31:0] model(input logic [1:0] ao, input logic o, f7v, f70,
                                         input logic [2:0] f3v, input logic [31:0] a, b,
                                         input bit em, output int lat);
      logic [63:0] p;
      logic [4:0] s;
      s = b[4:0];
      lat = 1;
      if (ao == 2'b00 || ao == 2'b11) return a + b;
      if (ao == 2'b01) return a - b;
      if (o && f70 && em) begin
         lat = 33;
         if (f3v[2] && (b == 0 || (!f3v[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) begin
            lat = 1;
            if (b == 0) return f3v[1] ? a : 32'hFFFFFFFF;
            return f3v[1] ? 32'h0 : a;
         end
         case (f3v)
            3'd0: return a * b;
            3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
            3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'h0, b}); return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: return $signed(a) / $signed(b);
            3'd5: return a / b;
            3'd6: return $signed(a) % $signed(b);
            default: return a % b;
         endcase
      end
      case (f3v)
         3'd0: return (o && f7v) ? a - b : a + b;
         3'd1: return a << s;
         3'd2: return {31'h0, $signed(a) < $signed(b)};
         3'd3: return {31'h0, a < b};
         3'd4: return a ^ b;
         3'd5: begin
            if (f7v) return $signed(a) >>> s;
            return a >> s;
         end
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic set_in(input logic [1:0] ao, input logic o, f7v, f70, input logic [2:0] f3v,
                         input logic [31:0] a, b);
      aluOp = ao; op = o; f7 = f7v; f7_0 = f70; f3 = f3v; srcA = a; srcB = b;
   endtask

   // issues one request from idle/done and checks latency, result and zero of both instances
   task automatic do_op(input string tag, input logic [1:0] ao, input logic o, f7v, f70,
                        input logic [2:0] f3v, input logic [31:0] a, b,
                        input logic [31:0] exp, input int lat);
      int cyc, lat2;
      logic [31:0] exp2;
      exp2 = model(ao, o, f7v, f70, f3v, a, b, 1'b0, lat2);
      @(negedge clk);
      set_in(ao, o, f7v, f70, f3v, a, b);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      chk({tag, "/nom_res"}, result2, exp2);
      chk({tag, "/nom_done"}, {31'h0, done2}, 32'd1);
      while (!done && cyc < 40) begin
         chk({tag, "/busy"}, {31'h0, busy}, 32'd1);
         @(negedge clk);
         cyc++;
      end
      chk({tag, "/lat"}, 32'(cyc), 32'(lat));
      chk({tag, "/res"}, result, exp);
      chk({tag, "/zero"}, {31'h0, zero}, {31'h0, exp == 0});
      chk({tag, "/busy_done"}, {31'h0, busy}, 32'd1);
   endtask

   initial begin
      int cyc, nd, lat;
      logic [31:0] a, b, exp;
      logic [1:0] ao;
      logic o, f7v, f70;
      logic [2:0] f3v;
      reset = 1'b1;
      start = 1'b0;
      set_in(2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'h0, busy}, 32'd0);
      chk("rst_done", {31'h0, done}, 32'd0);
      chk("rst_res", result, 32'h0);
      chk("rst_zero", {31'h0, zero}, 32'd1);
      reset = 1'b0;
      do_op("sub", 2'b10, 1, 1, 0, 3'b000, 32'd7, 32'd9, 32'hFFFFFFFE, 1);
      @(negedge clk);
      chk("pulse_end", {31'h0, done}, 32'd0);
      chk("idle_busy", {31'h0, busy}, 32'd0);
      chk("hold_res", result, 32'hFFFFFFFE);
      do_op("sra", 2'b10, 1, 1, 0, 3'b101, 32'h80000000, 32'd4, 32'hF8000000, 1);
      do_op("srl", 2'b10, 1, 0, 0, 3'b101, 32'h80000000, 32'd4, 32'h08000000, 1);
      do_op("sltu", 2'b10, 1, 0, 0, 3'b011, 32'd1, 32'hFFFFFFFF, 32'd1, 1);
      do_op("mulh", 2'b10, 1, 0, 1, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 33);
      do_op("mul", 2'b10, 1, 0, 1, 3'b000, 32'h12345, 32'h10, 32'h123450, 33);
      do_op("div_ovf", 2'b10, 1, 0, 1, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      do_op("rem_ovf", 2'b10, 1, 0, 1, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
      do_op("divu_z", 2'b10, 1, 0, 1, 3'b101, 32'h64, 32'h0, 32'hFFFFFFFF, 1);
      do_op("remu_z", 2'b10, 1, 0, 1, 3'b111, 32'h64, 32'h0, 32'h64, 1);
      do_op("rem_neg", 2'b10, 1, 0, 1, 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
      do_op("div_neg", 2'b10, 1, 0, 1, 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
      do_op("mulhsu", 2'b10, 1, 0, 1, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
      // start held every cycle during a multiply must be ignored until the done cycle
      @(negedge clk);
      set_in(2'b10, 1, 0, 1, 3'b000, 32'h12345, 32'h10);
      start = 1'b1;
      @(negedge clk);
      cyc = 1;
      nd = 0;
      set_in(2'b00, 0, 0, 0, 3'b000, 32'd5, 32'd6);
      while (cyc < 32) begin
         if (done) nd++;
         srcA = $urandom;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      if (done) nd++;
      @(negedge clk);
      chk("ign_early_done", 32'(nd), 32'd0);
      chk("ign_done", {31'h0, done}, 32'd1);
      chk("ign_res", result, 32'h123450);
      chk("ign_busy", {31'h0, busy}, 32'd1);
      // request in the done cycle is accepted back-to-back
      set_in(2'b00, 0, 0, 0, 3'b000, 32'd5, 32'd6);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_done", {31'h0, done}, 32'd1);
      chk("b2b_busy", {31'h0, busy}, 32'd1);
      chk("b2b_res", result, 32'd11);
      // reset during an iteration aborts without a done pulse
      @(negedge clk);
      set_in(2'b10, 1, 0, 1, 3'b000, 32'h12345, 32'h10);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", {31'h0, busy}, 32'd0);
      chk("abort_done", {31'h0, done}, 32'd0);
      chk("abort_res", result, 32'h0);
      chk("abort_zero", {31'h0, zero}, 32'd1);
      nd = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("abort_no_done", 32'(nd), 32'd0);
      do_op("nom_add", 2'b10, 1, 0, 1, 3'b000, 32'd100, 32'd23, 32'd2300, 33);
      chk("nom_add_res", result2, 32'd123);
      // random requests, biased toward M-extension encodings and divide corner operands
      repeat (40) begin
         ao = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'($urandom);
         o = ($urandom_range(0, 3) != 0);
         f7v = 1'($urandom);
         f70 = ($urandom_range(0, 2) != 0);
         f3v = 3'($urandom);
         a = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'h0;
            1: b = 32'hFFFFFFFF;
            2: b = $urandom_range(1, 40);
            default: b = $urandom;
         endcase
         exp = model(ao, o, f7v, f70, f3v, a, b, 1'b1, lat);
         do_op("rnd", ao, o, f7v, f70, f3v, a, b, exp, lat);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
